// File: rtl/zmod_prbs_checker_if.sv
// Receive-side bundle between the zmod loopback stage and the PRBS-15 checker.
// Optional err_sticky is present only when ZMOD_PRBS_STICKY_EN is defined.
interface zmod_prbs_checker_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             clear_counts;
  logic [3:0]       d_in;
  logic             d_valid;
  logic             locked;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] word_count;
  logic [CNT_W-1:0] lock_loss_count;
`ifdef ZMOD_PRBS_STICKY_EN
  logic             err_sticky;

  modport master (
    output enable, clear_counts, d_in, d_valid,
    input  locked, err_count, word_count, lock_loss_count, err_sticky
  );
  modport slave (
    input  enable, clear_counts, d_in, d_valid,
    output locked, err_count, word_count, lock_loss_count, err_sticky
  );
`else
  modport master (
    output enable, clear_counts, d_in, d_valid,
    input  locked, err_count, word_count, lock_loss_count
  );
  modport slave (
    input  enable, clear_counts, d_in, d_valid,
    output locked, err_count, word_count, lock_loss_count
  );
`endif
endinterface

// File: rtl/zmod_prbs_checker.sv
// Self-synchronising PRBS-15 checker for 4-bit words; word at cycle t reaches outputs at t+2, no backpressure.
// ZMOD_PRBS_STICKY_EN adds a sticky error flag that only clear_counts or reset clears.
module zmod_prbs_checker #(
  parameter int LOCK_CNT   = 32,
  parameter int UNLOCK_CNT = 8,
  parameter int CNT_W      = 32
) (
  input  logic                 rxclk,
  input  logic                 reset,
  zmod_prbs_checker_if.slave   bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_d;
  logic             r_dv;
  logic [14:0]      r_hist;
  logic [14:0]      w_hist_nxt;
  logic [14:0]      w_hist_pred;
  logic [3:0]       w_pred;
  logic [3:0]       w_mis;
  logic             w_err;
  logic [2:0]       w_popc;
  logic [GOOD_W-1:0] r_good;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [BAD_W-1:0]  r_bad;
  logic [BAD_W-1:0]  w_bad_nxt;
  logic             w_word_inc;
  logic             w_err_add;
  logic             w_loss_inc;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_word_count;
  logic [CNT_W-1:0] r_loss_count;
  logic [CNT_W:0]   w_err_sum;
  logic [CNT_W-1:0] w_err_sat;

  // Stage 1: register the incoming word.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_d  <= 4'd0;
      r_dv <= 1'b0;
    end else begin
      r_d  <= bus.d_in;
      r_dv <= bus.d_valid;
    end
  end

  // Bit 0 of the history is the most recent bit; each predicted bit feeds the next.
  always_comb begin
    w_hist_pred = r_hist;
    w_pred      = 4'd0;
    for (int j = 0; j < 4; j++) begin
      w_pred[j]   = w_hist_pred[13] ^ w_hist_pred[14];
      w_hist_pred = {w_hist_pred[13:0], w_pred[j]};
    end
  end

  assign w_mis  = r_d ^ w_pred;
  assign w_err  = |w_mis;
  assign w_popc = 3'(w_mis[0]) + 3'(w_mis[1]) + 3'(w_mis[2]) + 3'(w_mis[3]);

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_word_inc  = 1'b0;
    w_err_add   = 1'b0;
    w_loss_inc  = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (r_dv) begin
            w_hist_nxt = {r_hist[10:0], r_d[0], r_d[1], r_d[2], r_d[3]};
            // An all-zero history would "match" a dead link forever.
            if (!w_err && (r_hist != 15'd0)) begin
              if (r_good == GOOD_W'(LOCK_CNT - 1)) begin
                w_state_nxt = ST_LOCKED;
                w_good_nxt  = '0;
                w_bad_nxt   = '0;
              end else begin
                w_good_nxt = r_good + 1'b1;
              end
            end else begin
              w_good_nxt = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (r_dv) begin
            w_hist_nxt = w_hist_pred;
            w_word_inc = 1'b1;
            w_err_add  = 1'b1;
            if (w_err) begin
              if (r_bad == BAD_W'(UNLOCK_CNT - 1)) begin
                w_state_nxt = ST_SEARCH;
                w_loss_inc  = 1'b1;
                w_good_nxt  = '0;
                w_bad_nxt   = '0;
              end else begin
                w_bad_nxt = r_bad + 1'b1;
              end
            end else begin
              w_bad_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hist  <= 15'd0;
      r_good  <= '0;
      r_bad   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_good  <= w_good_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  // The wide sum carries into bit CNT_W on overflow, which pins the count at all-ones.
  assign w_err_sum = {1'b0, r_err_count} + (CNT_W + 1)'(w_popc);
  assign w_err_sat = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_err_count  <= '0;
      r_word_count <= '0;
      r_loss_count <= '0;
    end else if (bus.clear_counts) begin
      r_err_count  <= '0;
      r_word_count <= '0;
      r_loss_count <= '0;
    end else begin
      if (w_err_add) begin
        r_err_count <= w_err_sat;
      end
      if (w_word_inc && !(&r_word_count)) begin
        r_word_count <= r_word_count + 1'b1;
      end
      if (w_loss_inc && !(&r_loss_count)) begin
        r_loss_count <= r_loss_count + 1'b1;
      end
    end
  end

`ifdef ZMOD_PRBS_STICKY_EN
  logic r_err_sticky;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_err_sticky <= 1'b0;
    end else if (bus.clear_counts) begin
      r_err_sticky <= 1'b0;
    end else if ((w_err_add && w_err) || w_loss_inc) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign bus.err_sticky = r_err_sticky;
`endif

  assign bus.locked          = (r_state == ST_LOCKED);
  assign bus.err_count       = r_err_count;
  assign bus.word_count      = r_word_count;
  assign bus.lock_loss_count = r_loss_count;

endmodule
